// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder FSM states and bus-level constants.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    WRITE,
    ACK_WRITE,
    READ,
    ACK_READ,
    IGNORE
  } i2c_state_e;

  localparam logic       I2C_ACK   = 1'b0;
  localparam logic       I2C_NACK  = 1'b1;
  localparam logic       RW_WRITE  = 1'b0;
  localparam logic       RW_READ   = 1'b1;
  localparam logic [7:0] IDLE_FILL = 8'hFF;

  function automatic logic state_is_busy(input i2c_state_e s);
    return (s == ACK_ADDR) || (s == WRITE) || (s == ACK_WRITE) ||
           (s == READ) || (s == ACK_READ);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-stage synchronizers for SCL/SDA plus single-cycle edge, START and STOP strobes.
module i2c_line_sync (
  input  logic clk,
  input  logic i2c_reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       scl_lvl;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_prev_d = scl_sync_q[1];
    sda_prev_d = sda_sync_q[1];
  end

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (i2c_reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_lvl  = scl_sync_q[1];
  assign sda_lvl  = sda_sync_q[1];
  assign scl_rise = scl_lvl & ~scl_prev_q;
  assign scl_fall = ~scl_lvl & scl_prev_q;
  assign start    = scl_lvl & scl_prev_q & sda_prev_q & ~sda_lvl;
  assign stop     = scl_lvl & scl_prev_q & ~sda_prev_q & sda_lvl;

endmodule

// File: rtl/i2c_slave_core.sv
// I2C target with 7-bit addressing, no clock stretching; RX/TX bytes via external FIFOs.
//
// state     | meaning
// IDLE      | bus free, waiting for START
// ADDR      | shifting in address + R/W
// ACK_ADDR  | driving address ACK; TX byte fetched here for reads
// WRITE     | shifting in a write byte
// ACK_WRITE | driving ACK for a stored write byte
// READ      | serializing a TX byte onto SDA
// ACK_READ  | SDA released, sampling the master ACK/NACK
// IGNORE    | not addressed / done, waiting for START or STOP
module i2c_slave_core
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       i2c_reset,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_full,
  input  logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic       tx_rd_en,
  output logic       busy
);

  logic sda_lvl, scl_rise, scl_fall, start, stop;

  i2c_line_sync u_line_sync (
    .clk      (clk),
    .i2c_reset(i2c_reset),
    .scl_in   (i2c_scl),
    .sda_in   (i2c_sda),
    .sda_lvl  (sda_lvl),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_low_q, sda_low_d;
  logic       rw_q, rw_d;
  logic       load_q, load_d;
  logic       acked_q, acked_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_rd_en_q, tx_rd_en_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    shift_d     = shift_q;
    sda_low_d   = sda_low_q;
    rw_d        = rw_q;
    acked_d     = acked_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_rd_en_d  = 1'b0;
    // FIFO data is valid one cycle after the pop pulse reaches it.
    load_d      = tx_rd_en_q;
    if (load_q) shift_d = tx_data;

    if (start) begin
      state_d     = ADDR;
      sda_low_d   = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      acked_d     = 1'b0;
      load_d      = 1'b0;
    end else if (stop) begin
      state_d   = IDLE;
      sda_low_d = 1'b0;
      load_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR, WRITE: begin
          if (scl_rise) begin
            shift_d     = {shift_q[6:0], sda_lvl};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                sda_low_d = 1'b1;
                rw_d      = shift_q[0];
                state_d   = ACK_ADDR;
                if (shift_q[0] == RW_READ) begin
                  if (tx_empty) shift_d = IDLE_FILL;
                  else          tx_rd_en_d = 1'b1;
                end
              end else begin
                state_d = IGNORE;
              end
            end else if (!rx_full) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_low_d  = 1'b1;
              state_d    = ACK_WRITE;
            end else begin
              sda_low_d = 1'b0;
              state_d   = IGNORE;
            end
          end
        end
        ACK_ADDR: begin
          if (scl_fall) begin
            if (rw_q == RW_READ) begin
              sda_low_d = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b1};
              state_d   = READ;
            end else begin
              sda_low_d = 1'b0;
              state_d   = WRITE;
            end
          end
        end
        ACK_WRITE: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
            state_d   = WRITE;
          end
        end
        READ: begin
          if (scl_rise) begin
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
          end else if (scl_fall) begin
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              sda_low_d   = 1'b0;
              state_d     = ACK_READ;
            end else begin
              sda_low_d = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b1};
            end
          end
        end
        ACK_READ: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_ACK) begin
              acked_d = 1'b1;
              if (tx_empty) shift_d = IDLE_FILL;
              else          tx_rd_en_d = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end else if (scl_fall && acked_q) begin
            acked_d   = 1'b0;
            sda_low_d = ~shift_q[7];
            shift_d   = {shift_q[6:0], 1'b1};
            state_d   = READ;
          end
        end
        IDLE, IGNORE: begin
          sda_low_d = 1'b0;
        end
        default: begin
          state_d   = IDLE;
          sda_low_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i2c_reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      shift_q     <= 8'h00;
      sda_low_q   <= 1'b0;
      rw_q        <= RW_WRITE;
      load_q      <= 1'b0;
      acked_q     <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_rd_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      shift_q     <= shift_d;
      sda_low_q   <= sda_low_d;
      rw_q        <= rw_d;
      load_q      <= load_d;
      acked_q     <= acked_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_rd_en_q  <= tx_rd_en_d;
    end
  end

  assign i2c_sda  = sda_low_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_rd_en = tx_rd_en_q;
  assign busy     = state_is_busy(state_q);

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: bit-banged I2C master, FIFO models and a transaction-level reference.
module tb_i2c_slave_core;
  localparam int Q = 5;

  typedef struct {
    logic [6:0]      addr;
    logic            rw;
    int              n;
    logic [2:0][7:0] d;
    logic [2:0]      full;
    int              ntx;
    logic [2:0][7:0] tx;
  } vec_t;

  logic       clk = 1'b0;
  logic       i2c_reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       rx_full = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_empty;
  logic       tx_rd_en;
  logic       busy;
  wire        sda_w;

  pullup (sda_w);
  assign sda_w = sda_m ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  i2c_slave_core #(.SLAVE_ADDR(7'h50)) dut (
    .clk      (clk),
    .i2c_reset(i2c_reset),
    .i2c_scl  (scl),
    .i2c_sda  (sda_w),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_full  (rx_full),
    .tx_data  (tx_data),
    .tx_empty (tx_empty),
    .tx_rd_en (tx_rd_en),
    .busy     (busy)
  );

  // TX FIFO: bench writes tx_mem/tx_wr, the monitor owns tx_rd/tx_data.
  logic [7:0] tx_mem [0:255];
  logic [7:0] tx_wr = 8'd0;
  logic [7:0] tx_rd = 8'd0;
  assign tx_empty = (tx_rd == tx_wr);

  logic [7:0] rx_log [0:1023];
  int rx_total = 0, rd_total = 0, drive_cnt = 0, busy_cnt = 0;

  always @(posedge clk) begin
    if (tx_rd_en) begin
      rd_total <= rd_total + 1;
      if (tx_rd != tx_wr) begin
        tx_data <= tx_mem[tx_rd];
        tx_rd   <= tx_rd + 8'd1;
      end
    end
    if (rx_valid) begin
      rx_log[rx_total[9:0]] <= rx_data;
      rx_total <= rx_total + 1;
    end
    if (sda_m && (sda_w === 1'b0)) drive_cnt <= drive_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  int nvec = 0, nerr = 0;
  logic [7:0] mdl_fifo[$];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mbit(input logic b, output logic s);
    sda_m = b; tick(Q);
    scl = 1'b1; tick(Q);
    s = sda_w; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic mstart();
    sda_m = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic mstop();
    sda_m = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] data, input logic full, output logic ack);
    logic s;
    rx_full = full;
    for (int i = 7; i >= 0; i--) mbit(data[i], s);
    mbit(1'b1, ack);
    rx_full = 1'b0;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] data);
    logic s;
    data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mbit(1'b1, s);
      data = {data[6:0], s};
    end
    mbit(nack, s);
  endtask

  function automatic vec_t mk(input logic [6:0] a, input logic rw, input int n,
                              input logic [23:0] dd, input logic [2:0] full,
                              input int ntx, input logic [23:0] tt);
    vec_t r;
    r.addr = a; r.rw = rw; r.n = n; r.full = full; r.ntx = ntx;
    for (int i = 0; i < 3; i++) begin
      r.d[i]  = dd[23 - 8 * i -: 8];
      r.tx[i] = tt[23 - 8 * i -: 8];
    end
    return r;
  endfunction

  task automatic push_tx(input logic [7:0] b);
    tx_mem[tx_wr] = b;
    tx_wr = tx_wr + 8'd1;
    mdl_fifo.push_back(b);
  endtask

  // Reference: an addressed target ACKs until the first refused byte; reads pop the FIFO or send 0xFF.
  task automatic run_vec(input vec_t v, input string tag);
    int rx0, rd0, dr0, bz0, exp_rd;
    logic ack, match, alive;
    logic [7:0] got, exp_b;
    logic [7:0] exp_rx[$];
    rx0 = rx_total; rd0 = rd_total; dr0 = drive_cnt; bz0 = busy_cnt;
    exp_rd = 0;
    for (int i = 0; i < v.ntx; i++) push_tx(v.tx[i]);
    tick(2);
    match = (v.addr == 7'h50);
    mstart();
    write_byte({v.addr, v.rw}, 1'b0, ack);
    chk({tag, " addr_ack"}, ack, match ? 0 : 1);
    if (v.rw == 1'b0) begin
      alive = match;
      for (int i = 0; i < v.n; i++) begin
        write_byte(v.d[i], v.full[i], ack);
        if (alive && !v.full[i]) begin
          chk({tag, " wr_ack"}, ack, 0);
          exp_rx.push_back(v.d[i]);
        end else begin
          chk({tag, " wr_nack"}, ack, 1);
          alive = 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < v.n; i++) begin
        read_byte(i == v.n - 1, got);
        exp_b = 8'hFF;
        if (match && mdl_fifo.size() > 0) begin
          exp_b = mdl_fifo.pop_front();
          exp_rd++;
        end
        chk({tag, " rd_data"}, got, exp_b);
      end
    end
    mstop();
    chk({tag, " rx_count"}, rx_total - rx0, exp_rx.size());
    for (int k = 0; k < exp_rx.size() && rx0 + k < rx_total; k++)
      chk({tag, " rx_data"}, rx_log[rx0 + k], exp_rx[k]);
    if (exp_rx.size() > 0) chk({tag, " rx_hold"}, rx_data, exp_rx[exp_rx.size() - 1]);
    chk({tag, " tx_rd_en_count"}, rd_total - rd0, exp_rd);
    chk({tag, " busy_after_stop"}, busy, 0);
    chk({tag, " busy_seen"}, (busy_cnt - bz0) > 0, match);
    if (!match) chk({tag, " sda_undriven"}, drive_cnt - dr0, 0);
  endtask

  vec_t vecs[25];

  initial begin
    logic ack, s;
    logic [7:0] b;
    int rx0, rd0;

    vecs[0] = mk(7'h50, 1'b0, 2, 24'h3C8100, 3'b000, 0, 24'h0);
    vecs[1] = mk(7'h51, 1'b0, 1, 24'h550000, 3'b000, 0, 24'h0);
    vecs[2] = mk(7'h50, 1'b1, 2, 24'h000000, 3'b000, 2, 24'h5AC300);
    vecs[3] = mk(7'h50, 1'b0, 2, 24'h112200, 3'b010, 0, 24'h0);
    vecs[4] = mk(7'h50, 1'b1, 1, 24'h000000, 3'b000, 0, 24'h0);
    for (int i = 5; i < 25; i++)
      vecs[i] = mk(($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50, 1'($urandom),
                   int'($urandom_range(1, 3)), 24'($urandom), 3'($urandom) & 3'($urandom),
                   int'($urandom_range(0, 3)), 24'($urandom));

    tick(5);
    i2c_reset = 1'b0;
    tick(3);
    chk("reset rx_data", rx_data, 0);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset tx_rd_en", tx_rd_en, 0);
    chk("reset busy", busy, 0);
    chk("reset sda", sda_w, 1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Repeated START: write one byte, Sr, read one byte with NACK.
    push_tx(8'h77);
    rx0 = rx_total; rd0 = rd_total;
    mstart();
    write_byte(8'hA0, 1'b0, ack); chk("sr wr_addr_ack", ack, 0);
    write_byte(8'h10, 1'b0, ack); chk("sr wr_ack", ack, 0);
    mstart();
    write_byte(8'hA1, 1'b0, ack); chk("sr rd_addr_ack", ack, 0);
    read_byte(1'b1, b);
    chk("sr rd_data", b, mdl_fifo.pop_front());
    mstop();
    chk("sr rx_count", rx_total - rx0, 1);
    chk("sr rx_data", rx_log[rx0], 8'h10);
    chk("sr tx_rd_en_count", rd_total - rd0, 1);

    // Reset while the target drives bit 4 (a 0) of a read byte.
    push_tx(8'h00);
    void'(mdl_fifo.pop_front());
    rd0 = rd_total;
    mstart();
    write_byte(8'hA1, 1'b0, ack); chk("mid_rst addr_ack", ack, 0);
    for (int i = 0; i < 3; i++) mbit(1'b1, s);
    sda_m = 1'b1; tick(Q);
    scl = 1'b1; tick(2);
    chk("mid_rst driving", sda_w, 0);
    chk("mid_rst busy_before", busy, 1);
    i2c_reset = 1'b1; tick(1);
    chk("mid_rst sda_released", sda_w, 1);
    chk("mid_rst busy", busy, 0);
    chk("mid_rst rx_data", rx_data, 0);
    i2c_reset = 1'b0; tick(Q);
    scl = 1'b0; tick(Q);
    chk("mid_rst tx_rd_en_count", rd_total - rd0, 1);
    run_vec(mk(7'h50, 1'b0, 2, 24'hA55A00, 3'b000, 0, 24'h0), "post_rst");

    for (int i = 5; i < 25; i++) run_vec(vecs[i], $sformatf("rnd%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
